alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq_pkg.sv | 15 +
 rtl/alu_cmd_seq_fifo.sv | 58 +++++
 rtl/alu_cmd_seq.sv | 146 ++++++++++++++
 tb/tb_alu_cmd_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_seq_pkg.sv
// Shared constants and FSM state type for the ALU command sequencer.
package alu_cmd_seq_pkg;

    localparam int DATA_W    = 6;   // operand / result width
    localparam int FXN_W     = 3;   // ALU function-select width
    localparam int DEPTH_DEF = 4;   // default command FIFO depth
    localparam int CNT_W     = 8;   // completed-result counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_seq_fifo.sv
// Command FIFO: DEPTH entries of WIDTH bits, count-based full/empty,
// head word presented combinationally on rdata.
module cmd_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];

    // Storage write; contents are don't-care until the count says otherwise.
    // NOTE: the array has no reset -- count_q gates every read, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: queues {a,b,fxn} commands, feeds them one at a
// time to an external combinational ALU and holds each result until taken.
module alu_cmd_seq #(
    parameter int DEPTH  = alu_cmd_seq_pkg::DEPTH_DEF,
    parameter int DATA_W = alu_cmd_seq_pkg::DATA_W,
    parameter int FXN_W  = alu_cmd_seq_pkg::FXN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [FXN_W-1:0]  in_fxn,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FXN_W-1:0]  alu_fxn,
    input  logic [DATA_W-1:0] alu_x,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_neg,
    output logic [7:0]        res_cnt
);

    import alu_cmd_seq_pkg::*;

    localparam int CMD_W = 2 * DATA_W + FXN_W;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [FXN_W-1:0]  alu_fxn_q, alu_fxn_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic              res_zero_q, res_zero_d;
    logic              res_neg_q, res_neg_d;
    logic [7:0]        res_cnt_q, res_cnt_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_head;

    // Held low during reset so nothing is offered an accept mid-reset.
    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_a, in_b, in_fxn}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, pop decision and result capture for IDLE -> EXEC -> HOLD.
    always_comb begin
        // NOTE: every _d gets its hold value first so no branch can leave one unassigned (no latches).
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fxn_d   = alu_fxn_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_zero_d  = res_zero_q;
        res_neg_d   = res_neg_q;
        res_cnt_d   = res_cnt_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                      = 1'b1;
                    {alu_a_d, alu_b_d, alu_fxn_d} = fifo_head;
                    state_d                       = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = alu_x;
                res_zero_d  = (alu_x == '0);
                res_neg_d   = alu_x[DATA_W-1];
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_cnt_d   = res_cnt_q + 8'd1;
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop                      = 1'b1;
                        {alu_a_d, alu_b_d, alu_fxn_d} = fifo_head;
                        state_d                       = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fxn_q   <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fxn_q   <= alu_fxn_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_zero_q  <= res_zero_d;
            res_neg_q   <= res_neg_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fxn   = alu_fxn_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign res_zero  = res_zero_q;
    assign res_neg   = res_neg_q;
    assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: the ALU is modelled as X = A+B mod 64; a queue of
// accepted commands predicts every result, checked on each falling edge.
module tb_alu_cmd_seq;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] f;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_a = '0;
    logic [5:0] in_b = '0;
    logic [2:0] in_fxn = '0;
    logic [5:0] alu_a, alu_b, alu_x;
    logic [2:0] alu_fxn;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [5:0] res_data;
    logic       res_zero, res_neg;
    logic [7:0] res_cnt;

    int checks = 0;
    int errors = 0;

    cmd_t       exp_q[$];
    logic [7:0] exp_cnt = '0;
    int         cyc = 0;
    int         last_hs = -100;
    logic [2:0] hs_fxn_q[$];
    int         hs_gap_q[$];

    always #5 clk = ~clk;

    assign alu_x = alu_a + alu_b;

    alu_cmd_seq #(.DEPTH(4), .DATA_W(6), .FXN_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_fxn    (in_fxn),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fxn   (alu_fxn),
        .alu_x     (alu_x),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_neg   (res_neg),
        .res_cnt   (res_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Offer one command starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic push_cmd(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
        bit ok = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_fxn   = f;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("push_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    // Reference model: results emerge in acceptance order, each equal to a+b mod 64.
    always @(negedge clk) begin
        cmd_t       c;
        logic [5:0] r;
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_cnt = '0;
            last_hs = -100;
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_res_valid", {31'd0, res_valid}, 32'd0);
            check("rst_res_cnt", {24'd0, res_cnt}, 32'd0);
            check("rst_regs", {15'd0, alu_a, alu_b, alu_fxn, res_data, res_zero, res_neg}, 32'd0);
        end else begin
            check("res_cnt", {24'd0, res_cnt}, {24'd0, exp_cnt});
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_res_valid", {31'd0, res_valid}, 32'd0);
                end else begin
                    c = exp_q[0];
                    r = c.a + c.b;
                    check("res_data", {26'd0, res_data}, {26'd0, r});
                    check("res_zero", {31'd0, res_zero}, {31'd0, (r == 6'd0)});
                    check("res_neg", {31'd0, res_neg}, {31'd0, r[5]});
                    check("alu_ops", {17'd0, alu_a, alu_b, alu_fxn}, {17'd0, c});
                end
                if (res_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    check("result_spacing", {31'd0, (cyc - last_hs >= 2)}, 32'd1);
                    hs_fxn_q.push_back(alu_fxn);
                    hs_gap_q.push_back(cyc - last_hs);
                    last_hs = cyc;
                    exp_cnt++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{a: in_a, b: in_b, f: in_fxn});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op: 1 + 63 = 0 -> zero flag, two-edge latency.
        push_cmd(6'd1, 6'd63, 3'd0);
        next_cycle();
        check("lat_alu_a", {26'd0, alu_a}, 32'd1);
        check("lat_alu_b", {26'd0, alu_b}, 32'd63);
        check("lat_not_yet_valid", {31'd0, res_valid}, 32'd0);
        next_cycle();
        check("lat_res_valid", {31'd0, res_valid}, 32'd1);
        check("lat_res_data", {26'd0, res_data}, 32'd0);
        check("lat_res_zero", {31'd0, res_zero}, 32'd1);
        check("lat_res_neg", {31'd0, res_neg}, 32'd0);

        // Fill the FIFO behind the held result.
        push_cmd(6'd2, 6'd3, 3'd1);
        push_cmd(6'd10, 6'd20, 3'd2);
        push_cmd(6'd31, 6'd31, 3'd3);
        push_cmd(6'd63, 6'd63, 3'd4);
        check("fill_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_a = 6'd7; in_b = 6'd7; in_fxn = 3'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fifth_refused", {31'd0, in_ready}, 32'd0);
        end
        next_cycle();
        in_valid = 1'b0;

        // Backpressure: result and ALU operands frozen.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check("bp_hold", {18'd0, res_valid, res_data, alu_a, alu_b, alu_fxn}, {18'd1, 6'd0, 6'd1, 6'd63, 3'd0});
        end
        res_ready = 1'b1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            next_cycle();
            done = (res_cnt == 8'd5);
        end
        check("drain_cnt", {24'd0, res_cnt}, 32'd5);
        res_ready = 1'b0;

        // Reset while a result is held with three commands queued.
        push_cmd(6'd4, 6'd4, 3'd1);
        push_cmd(6'd5, 6'd5, 3'd2);
        push_cmd(6'd6, 6'd6, 3'd3);
        push_cmd(6'd8, 6'd8, 3'd4);
        check("pre_rst_held", {30'd0, res_valid, in_ready}, 32'd3);
        rst = 1'b1;
        #1;
        check("async_rst_regs", {7'd0, res_valid, res_cnt, alu_a, alu_b, alu_fxn, res_data[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_idle", {23'd0, res_valid, res_cnt}, 32'd0);
        end
        next_cycle();

        // Streaming: eight commands, one result every two cycles.
        hs_fxn_q.delete();
        hs_gap_q.delete();
        for (int i = 0; i < 8; i++) push_cmd(6'(i), 6'(3 * i), 3'(i));
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            next_cycle();
            done = (hs_fxn_q.size() >= 8);
        end
        check("stream_count", hs_fxn_q.size(), 32'd8);
        for (int k = 0; k < 8 && k < hs_fxn_q.size(); k++) begin
            check("stream_fxn", {29'd0, hs_fxn_q[k]}, k);
            if (k > 0) check("stream_gap", hs_gap_q[k], 32'd2);
        end
        check("stream_res_cnt", {24'd0, res_cnt}, 32'd8);

        // Random traffic with random backpressure and one reset in the middle.
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 6'($urandom);
            in_b      = 6'($urandom);
            in_fxn    = 3'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            if (i == 250) rst = 1'b1;
            next_cycle();
            rst = 1'b0;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (30) next_cycle();
        check("random_drained", exp_q.size(), 32'd0);

        // Counter wrap: 256 results, the last one 31+1 = 32 (negative).
        pulse_reset();
        hs_fxn_q.delete();
        for (int i = 0; i < 255; i++) push_cmd(6'($urandom), 6'($urandom), 3'($urandom));
        push_cmd(6'd31, 6'd1, 3'd0);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (res_valid && hs_fxn_q.size() == 255) begin
                check("wrap_last_data", {26'd0, res_data}, 32'd32);
                check("wrap_last_neg", {31'd0, res_neg}, 32'd1);
                done = 1;
            end
        end
        check("wrap_last_seen", {31'd0, done}, 32'd1);
        repeat (3) next_cycle();
        check("wrap_total", hs_fxn_q.size(), 32'd256);
        check("wrap_res_cnt", {24'd0, res_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
